// File: rtl/wbdbgbus_pkg.sv
// Shared constants, command payload type and TX frame helpers for the debug-bus host.
package wbdbgbus_pkg;

    localparam int unsigned FRAME_W     = 40;
    localparam int unsigned CMD_W       = 36;
    localparam int unsigned FRAME_BYTES = 5;

    localparam logic [3:0] RESP_INT_1 = 4'b1000;
    localparam logic [3:0] RESP_INT_2 = 4'b1001;
    localparam logic [3:0] RESP_INT_3 = 4'b1010;
    localparam logic [3:0] RESP_INT_4 = 4'b1011;
    localparam logic [3:0] CMD_RESET  = 4'b1111;

    typedef struct packed {
        logic [3:0]  opcode;
        logic [31:0] payload;
    } cmd_t;

    typedef enum logic {
        TX_IDLE,
        TX_SEND
    } tx_state_t;

    // Byte idx (1..5) of the wire frame, MSB first
    function automatic logic [7:0] frame_byte(input cmd_t cmd, input logic [2:0] idx);
        logic [FRAME_W-1:0] frame;
        frame = {4'b0000, cmd};
        case (idx)
            3'd1:    frame_byte = frame[39:32];
            3'd2:    frame_byte = frame[31:24];
            3'd3:    frame_byte = frame[23:16];
            3'd4:    frame_byte = frame[15:8];
            default: frame_byte = frame[7:0];
        endcase
    endfunction

    // Interrupt opcodes share the 2'b10 prefix; the low two bits pick the line
    function automatic logic is_int_op(input logic [3:0] op);
        return op[3:2] == RESP_INT_1[3:2];
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver with two-flop input sync; one-cycle o_valid per good byte.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic       o_valid,
    output logic [7:0] o_data
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    rx_state_t     state;
    logic          rx_meta;
    logic          rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= RX_IDLE;
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
            o_valid <= 1'b0;
            case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    if (!rx_s) state <= RX_START;
                end
                // Re-check the start bit at its midpoint to reject glitches
                RX_START: begin
                    if (cnt == CW'(CLKS_PER_BIT / 2 - 1)) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[7:1]};
                        if (bit_idx == 3'd7) state <= RX_STOP;
                        else bit_idx <= bit_idx + 3'd1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
                        if (rx_s) begin
                            o_valid <= 1'b1;
                            o_data  <= shreg;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter. A byte in flight always completes; reset only takes hold when idle.
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_tx
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);

    logic          busy;
    logic [9:0]    shreg;
    logic [CW-1:0] baud_cnt;
    logic [3:0]    bit_cnt;

    always_ff @(posedge i_clk) begin
        if (busy) begin
            if (baud_cnt == CW'(CLKS_PER_BIT - 1)) begin
                baud_cnt <= '0;
                if (bit_cnt == 4'd9) begin
                    busy    <= 1'b0;
                    o_ready <= 1'b1;
                    o_tx    <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    shreg   <= {1'b1, shreg[9:1]};
                    o_tx    <= shreg[1];
                end
            end else begin
                baud_cnt <= baud_cnt + CW'(1);
            end
        end else if (i_rst) begin
            o_ready  <= 1'b1;
            o_tx     <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else if (i_valid && o_ready) begin
            busy     <= 1'b1;
            o_ready  <= 1'b0;
            shreg    <= {1'b1, i_data, 1'b0};
            o_tx     <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end
    end

endmodule

// File: rtl/wbdbgbus_frame_rx.sv
// Response frame assembler and dispatcher. WBDBGBUS_HOST_DROP_EN adds the partial-frame drop timer.
module wbdbgbus_frame_rx
    import wbdbgbus_pkg::*;
#(
    parameter int unsigned DROP_CLKS = 2500000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [7:0]       i_data,
    output logic             o_resp_valid,
    output logic [CMD_W-1:0] o_resp_data,
    output logic [3:0]       o_interrupt,
    output logic             o_frame_err
);

    if (DROP_CLKS < 2) begin : g_bad_drop_clks
        $error("DROP_CLKS must be at least 2");
    end

    logic [FRAME_W-1:0] shreg;
    logic [2:0]         count;
    logic               done;

`ifdef WBDBGBUS_HOST_DROP_EN
    localparam int unsigned TIMER_W = $clog2(DROP_CLKS + 1);
    logic [TIMER_W-1:0] timer;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            shreg        <= '0;
            count        <= '0;
            done         <= 1'b0;
            o_resp_valid <= 1'b0;
            o_resp_data  <= '0;
            o_interrupt  <= '0;
            o_frame_err  <= 1'b0;
`ifdef WBDBGBUS_HOST_DROP_EN
            timer        <= TIMER_W'(DROP_CLKS);
`endif
        end else begin
            o_resp_valid <= 1'b0;
            o_interrupt  <= '0;
            o_frame_err  <= 1'b0;
            done         <= 1'b0;

            // Dispatch the completed frame one cycle after its last byte
            if (done) begin
                o_frame_err <= |shreg[39:36];
                if (is_int_op(shreg[35:32])) begin
                    o_interrupt <= 4'b0001 << shreg[33:32];
                end else begin
                    o_resp_valid <= 1'b1;
                    o_resp_data  <= shreg[35:0];
                end
            end

            if (i_valid) begin
                shreg <= {shreg[31:0], i_data};
                if (count == 3'(FRAME_BYTES - 1)) begin
                    count <= '0;
                    done  <= 1'b1;
                end else begin
                    count <= count + 3'd1;
                end
`ifdef WBDBGBUS_HOST_DROP_EN
                timer <= TIMER_W'(DROP_CLKS);
            end else if (count != '0) begin
                // Silent discard of a stalled partial frame
                if (timer == TIMER_W'(1)) begin
                    count <= '0;
                    timer <= TIMER_W'(DROP_CLKS);
                end else begin
                    timer <= timer - TIMER_W'(1);
                end
`endif
            end
        end
    end

endmodule

// File: rtl/wbdbgbus_host.sv
// Debug-bus host: serialises 36-bit commands to 5-byte UART frames and decodes response frames.
// Define WBDBGBUS_HOST_DROP_EN to enable discarding of stalled partial receive frames.
module wbdbgbus_host
    import wbdbgbus_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 25000000,
    parameter int unsigned UART_BAUD = 9600,
    parameter int unsigned DROP_CLKS = 2500000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    output logic             o_tx,
    input  logic             i_rx,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [CMD_W-1:0] i_cmd_data,
    output logic             o_resp_valid,
    output logic [CMD_W-1:0] o_resp_data,
    output logic [3:0]       o_interrupt,
    output logic             o_frame_err
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / UART_BAUD;

    tx_state_t  state;
    logic [2:0] idx;
    cmd_t       cmd_q;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;

    // TX sequencer: a valid is issued only when the previous cycle had none,
    // so uart_tx's ready has time to drop before the next byte is offered
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= TX_IDLE;
            idx         <= 3'd1;
            cmd_q       <= '0;
            tx_valid    <= 1'b0;
            tx_data     <= '0;
            o_cmd_ready <= 1'b1;
        end else begin
            tx_valid <= 1'b0;
            case (state)
                TX_IDLE: begin
                    if (i_cmd_valid && o_cmd_ready) begin
                        cmd_q       <= i_cmd_data;
                        idx         <= 3'd1;
                        state       <= TX_SEND;
                        o_cmd_ready <= 1'b0;
                    end
                end
                TX_SEND: begin
                    if (tx_valid) begin
                        if (idx == 3'(FRAME_BYTES)) begin
                            state       <= TX_IDLE;
                            o_cmd_ready <= 1'b1;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else if (tx_ready) begin
                        tx_valid <= 1'b1;
                        tx_data  <= frame_byte(cmd_q, idx);
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (tx_valid),
        .i_data  (tx_data),
        .o_ready (tx_ready),
        .o_tx    (o_tx)
    );

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_rx (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_rx    (i_rx),
        .o_valid (rx_valid),
        .o_data  (rx_data)
    );

    wbdbgbus_frame_rx #(
        .DROP_CLKS(DROP_CLKS)
    ) u_frame_rx (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_valid      (rx_valid),
        .i_data       (rx_data),
        .o_resp_valid (o_resp_valid),
        .o_resp_data  (o_resp_data),
        .o_interrupt  (o_interrupt),
        .o_frame_err  (o_frame_err)
    );

endmodule
